load_store_unit: RTL and testbench

//  MEM-stage load/store sequencer between pipeline and data_memory. Turns byte/half/word

---
 rtl/load_store_unit_if.sv | 41 ++++
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Purpose : Bundles the pipeline-side request/response signals and the
//           data_memory-side signals of the load/store unit into one bus.
// Signals :
//   req, req_we, req_size, req_unsigned, addr, wdata : access request (pipeline -> LSU)
//   busy, ack, rdata, misalign                       : status/result  (LSU -> pipeline)
//   mem_address, mem_write, mem_wdata                : memory request (LSU -> memory)
//   mem_rdata                                        : memory read data (memory -> LSU)
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (pipeline plus data memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        misalign;

  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, req_we, req_size, req_unsigned, addr, wdata, mem_rdata,
    output busy, ack, rdata, misalign, mem_address, mem_write, mem_wdata
  );

  modport master (
    output req, req_we, req_size, req_unsigned, addr, wdata, mem_rdata,
    input  busy, ack, rdata, misalign, mem_address, mem_write, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Purpose : MEM-stage sequencer between the pipeline and a little-endian
//           data memory that always writes whole 32-bit words. Byte/half
//           loads are extracted from an aligned word read and sign- or
//           zero-extended; byte/half stores are done as read-modify-write.
//           busy stalls the pipeline, ack pulses for one cycle on completion.
// Parameters:
//   ADDR_BITS : byte-address bits kept (default 16, accesses wrap in 64 KiB)
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// Optional feature:
//   MISALIGN_TRAP_EN : when defined, misaligned half/word accesses complete
//                      immediately with misalign=1, rdata=0 and no write.
//                      When undefined, misalign is tied low and offending low
//                      address bits simply select the containing word/lane.
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]           r_state;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_word;
  logic [31:0]          r_rdata;

  logic                 w_accept;
  logic                 w_trap;
  logic                 w_needRead;
  logic [31:0]          w_mergedWord;

  // Picks the addressed lane out of an aligned word and extends it.
  // Size 2'b11 falls into the default branch and behaves as a word.
  function automatic logic [31:0] extractLoad(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  offset,
    input logic        isUnsigned
  );
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] result;
    byteVal = word[{offset, 3'b000} +: 8];
    halfVal = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = isUnsigned ? {24'h0, byteVal} : {{24{byteVal[7]}}, byteVal};
      SZ_HALF: result = isUnsigned ? {16'h0, halfVal} : {{16{halfVal[15]}}, halfVal};
      default: result = word;
    endcase
    return result;
  endfunction

  // Builds the word written back to memory: the old word with the selected
  // lane(s) replaced for SB/SH, or the store data itself for a word store.
  function automatic logic [31:0] mergeStore(
    input logic [31:0] oldWord,
    input logic [31:0] storeData,
    input logic [1:0]  size,
    input logic [1:0]  offset
  );
    logic [31:0] result;
    result = oldWord;
    case (size)
      SZ_BYTE: result[{offset, 3'b000} +: 8] = storeData[7:0];
      SZ_HALF: begin
        if (offset[1]) begin
          result[31:16] = storeData[15:0];
        end else begin
          result[15:0] = storeData[15:0];
        end
      end
      default: result = storeData;
    endcase
    return result;
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.req;

  // Loads and sub-word stores need the current word first; only a word
  // store (size[1] set) can go straight to the write cycle.
  assign w_needRead = !bus.req_we || !bus.req_size[1];

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_trap = ((bus.req_size == SZ_HALF) && bus.addr[0]) ||
                  (bus.req_size[1] && (bus.addr[1:0] != 2'b00));

  // The flag is decided when a request is accepted and is held until the
  // next acceptance, so it is stable throughout the ack cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_misalign <= w_trap;
    end
  end

  assign bus.misalign = r_misalign;
`else
  assign w_trap       = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_word     <= 32'h0;
      r_rdata    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.addr[ADDR_BITS-1:0];
            r_wdata    <= bus.wdata;
            if (w_trap) begin
              r_rdata <= 32'h0;
              r_state <= S_RESP;
            end else if (w_needRead) begin
              r_state <= S_READ;
            end else begin
              r_state <= S_WRITE;
            end
          end
        end
        S_READ: begin
          r_word <= bus.mem_rdata;
          if (r_we) begin
            r_state <= S_WRITE;
          end else begin
            // The load result is registered here so rdata keeps its value
            // after the ack cycle without any extra holding logic.
            r_rdata <= extractLoad(bus.mem_rdata, r_size, r_addr[1:0], r_unsigned);
            r_state <= S_RESP;
          end
        end
        S_WRITE: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_mergedWord = mergeStore(r_word, r_wdata, r_size, r_addr[1:0]);

  // mem_write and ack are gated with reset so an access aborted by reset
  // neither reaches memory nor reports completion in that same cycle.
  assign bus.mem_write   = (r_state == S_WRITE) && !reset;
  assign bus.mem_wdata   = (r_state == S_WRITE) ? w_mergedWord : 32'h0;
  assign bus.mem_address = 32'({r_addr[ADDR_BITS-1:2], 2'b00});

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.ack   = (r_state == S_RESP) && !reset;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Purpose : Self-checking bench for load_store_unit. Provides a word-wide
//           data memory, a directed vector table, two hand-written
//           multi-cycle sequences (reset abort, held request) and random
//           accesses checked against a byte-array reference model.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic clk;
  logic reset;
  logic clearMem;

  int assertCount;
  int failCount;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT: combinational read, whole-word write.
  logic [31:0] tbMem [0:16383];
  assign bus.mem_rdata = tbMem[bus.mem_address[15:2]];

  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < 16384; i++) tbMem[i] <= 32'h0;
    end else if (bus.mem_write) begin
      tbMem[bus.mem_address[15:2]] <= bus.mem_wdata;
    end
  end

  // Reference model: memory as 64 KiB of bytes.
  logic [7:0] refMem [0:65535];

  function automatic logic [31:0] refWord(input int base);
    return {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
  endfunction

  function automatic logic [31:0] refLoad(input int a, input logic [1:0] size, input logic uns);
    int v;
    int b;
    case (size)
      2'b00: begin
        v = refMem[a];
        if (!uns && v >= 128) v = v - 256;
      end
      2'b01: begin
        b = (a / 2) * 2;
        v = refMem[b] + 256 * refMem[b+1];
        if (!uns && v >= 32768) v = v - 65536;
      end
      default: return refWord((a / 4) * 4);
    endcase
    return 32'(v);
  endfunction

  task automatic refStore(input int a, input logic [1:0] size, input logic [31:0] wd);
    int b;
    case (size)
      2'b00: refMem[a] = wd[7:0];
      2'b01: begin
        b = (a / 2) * 2;
        refMem[b]   = wd[7:0];
        refMem[b+1] = wd[15:8];
      end
      default: begin
        b = (a / 4) * 4;
        refMem[b]   = wd[7:0];
        refMem[b+1] = wd[15:8];
        refMem[b+2] = wd[23:16];
        refMem[b+3] = wd[31:24];
      end
    endcase
  endtask

  function automatic bit refTrap(input int a, input logic [1:0] size);
`ifdef MISALIGN_TRAP_EN
    return ((size == 2'b01) && (a % 2 != 0)) || ((size >= 2'b10) && (a % 4 != 0));
`else
    return 1'b0 & size[0] & a[0];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one request in cycle 0 and observes the DUT mid-cycle until ack
  // or an 8-cycle budget runs out (ackCycle stays -1 in that case).
  task automatic applyStimulus(
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output int          ackCycle,
    output int          writeCycle,
    output int          writeCount,
    output logic [31:0] writeData,
    output logic [31:0] rd,
    output logic        mis,
    output logic [31:0] memAddr
  );
    ackCycle = -1; writeCycle = -1; writeCount = 0;
    writeData = 32'h0; rd = 32'h0; mis = 1'b0; memAddr = 32'h0;
    @(negedge clk);
    bus.req = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.addr = addr; bus.wdata = wd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req = 1'b0;
        memAddr = bus.mem_address;
      end
      if (bus.mem_write) begin
        writeCount++;
        writeCycle = c;
        writeData  = bus.mem_wdata;
      end
      if (bus.ack) begin
        ackCycle = c;
        rd  = bus.rdata;
        mis = bus.misalign;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          expAck;
    logic [31:0] expRdata;
    bit          checkRdata;
    int          expWrites;
    logic [31:0] expWdata;
    logic        expMis;
    logic [31:0] expMemAddr;
  } vec_t;

  vec_t vecs [15];

  int          ackCycle, writeCycle, writeCount;
  logic [31:0] writeData, rd, memAddr;
  logic        mis;
  logic [31:0] modelRdata;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    clearMem    = 1'b1;
    reset       = 1'b1;
    bus.req = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < 65536; i++) refMem[i] = 8'h00;

    repeat (3) @(negedge clk);
    clearMem = 1'b0;
    reset    = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset busy",        32'(bus.busy),      32'h0);
    checkOutput("reset ack",         32'(bus.ack),       32'h0);
    checkOutput("reset misalign",    32'(bus.misalign),  32'h0);
    checkOutput("reset mem_write",   32'(bus.mem_write), 32'h0);
    checkOutput("reset rdata",       bus.rdata,          32'h0);
    checkOutput("reset mem_address", bus.mem_address,    32'h0);
    checkOutput("reset mem_wdata",   bus.mem_wdata,      32'h0);

    vecs[0]  = '{"SW 0x100",       1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344, 2, 32'h0,          1'b0, 1, 32'h1122_3344, 1'b0, 32'h100};
    vecs[1]  = '{"LW 0x100",       1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         2, 32'h1122_3344,  1'b1, 0, 32'h0,         1'b0, 32'h100};
    vecs[2]  = '{"LB 0x103",       1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         2, 32'h0000_0011,  1'b1, 0, 32'h0,         1'b0, 32'h100};
    vecs[3]  = '{"LH 0x102",       1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,         2, 32'h0000_1122,  1'b1, 0, 32'h0,         1'b0, 32'h100};
    vecs[4]  = '{"SB 0x100 80",    1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h0000_0080, 3, 32'h0,          1'b0, 1, 32'h1122_3380, 1'b0, 32'h100};
    vecs[5]  = '{"LB 0x100",       1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0,         2, 32'hFFFF_FF80,  1'b1, 0, 32'h0,         1'b0, 32'h100};
    vecs[6]  = '{"LBU 0x100",      1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0,         2, 32'h0000_0080,  1'b1, 0, 32'h0,         1'b0, 32'h100};
    vecs[7]  = '{"SW restore",     1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h1122_3344, 2, 32'h0,          1'b0, 1, 32'h1122_3344, 1'b0, 32'h100};
    vecs[8]  = '{"SB 0x101 AB",    1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB, 3, 32'h0,          1'b0, 1, 32'h1122_AB44, 1'b0, 32'h100};
    vecs[9]  = '{"LW after SB",    1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         2, 32'h1122_AB44,  1'b1, 0, 32'h0,         1'b0, 32'h100};
`ifdef MISALIGN_TRAP_EN
    vecs[10] = '{"LW 0x102 trap",  1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         1, 32'h0,          1'b1, 0, 32'h0,         1'b1, 32'h100};
`else
    vecs[10] = '{"LW 0x102",       1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         2, 32'h1122_AB44,  1'b1, 0, 32'h0,         1'b0, 32'h100};
`endif
    vecs[11] = '{"LH 0x100 signed",1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,         2, 32'hFFFF_AB44,  1'b1, 0, 32'h0,         1'b0, 32'h100};
    vecs[12] = '{"LW wrap 10100",  1'b0, 2'b10, 1'b0, 32'h0001_0100, 32'h0,         2, 32'h1122_AB44,  1'b1, 0, 32'h0,         1'b0, 32'h100};
    vecs[13] = '{"SH 0x102 5A5A",  1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_5A5A, 3, 32'h0,          1'b0, 1, 32'h5A5A_AB44, 1'b0, 32'h100};
    vecs[14] = '{"LHU 0x102",      1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         2, 32'h0000_5A5A,  1'b1, 0, 32'h0,         1'b0, 32'h100};

    $display("[TB] directed vectors");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    ackCycle, writeCycle, writeCount, writeData, rd, mis, memAddr);
      checkOutput({vecs[i].name, " ack cycle"},   32'(ackCycle),   32'(vecs[i].expAck));
      checkOutput({vecs[i].name, " write count"}, 32'(writeCount), 32'(vecs[i].expWrites));
      checkOutput({vecs[i].name, " misalign"},    32'(mis),        32'(vecs[i].expMis));
      checkOutput({vecs[i].name, " mem_address"}, memAddr,         vecs[i].expMemAddr);
      if (vecs[i].checkRdata)
        checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].expRdata);
      if (vecs[i].expWrites > 0) begin
        checkOutput({vecs[i].name, " write cycle"}, 32'(writeCycle), 32'(vecs[i].expAck - 1));
        checkOutput({vecs[i].name, " mem_wdata"},   writeData,       vecs[i].expWdata);
      end
    end
    checkOutput("memory word 0x100", tbMem[64], 32'h5A5A_AB44);

    $display("[TB] reset during SH write cycle");
    @(negedge clk);
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.addr = 32'h0000_0102; bus.wdata = 32'h0000_BEEF;
    @(negedge clk);
    bus.req = 1'b0;
    checkOutput("abort busy in READ", 32'(bus.busy), 32'h1);
    @(negedge clk);
    checkOutput("abort mem_write in WRITE", 32'(bus.mem_write), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("abort mem_write gated", 32'(bus.mem_write), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy after", 32'(bus.busy), 32'h0);
    checkOutput("abort ack after",  32'(bus.ack),  32'h0);
    checkOutput("abort rdata after", bus.rdata,    32'h0);
    checkOutput("abort memory unchanged", tbMem[64], 32'h5A5A_AB44);

    $display("[TB] request held across a full LW");
    begin
      logic expBusy [1:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic expAck  [1:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      bus.req = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
      bus.req_unsigned = 1'b0; bus.addr = 32'h0000_0100; bus.wdata = 32'h0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        checkOutput($sformatf("held req busy c%0d", c), 32'(bus.busy), 32'(expBusy[c]));
        checkOutput($sformatf("held req ack c%0d", c),  32'(bus.ack),  32'(expAck[c]));
        if (c == 5) checkOutput("held req rdata", bus.rdata, 32'h5A5A_AB44);
        if (c == 4) bus.req = 1'b0;
      end
    end

    $display("[TB] random accesses against reference model");
    refStore(32'h100, 2'b10, 32'h5A5A_AB44);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelRdata = 32'h0;
    for (int n = 0; n < 300; n++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] upper, addr, wd, expWord;
      int          a, expAckCycle;
      bit          trap;
      we    = 1'($urandom);
      size  = 2'($urandom);
      uns   = 1'($urandom);
      upper = $urandom;
      a     = 32'h200 + $urandom_range(0, 63);
      addr  = {upper[31:16], 16'(a)};
      wd    = $urandom;
      trap  = refTrap(a, size);

      if (trap) expAckCycle = 1;
      else if (!we || size >= 2'b10) expAckCycle = 2;
      else expAckCycle = 3;

      if (trap) modelRdata = 32'h0;
      else if (!we) modelRdata = refLoad(a, size, uns);
      else refStore(a, size, wd);
      expWord = refWord((a / 4) * 4);

      applyStimulus(we, size, uns, addr, wd,
                    ackCycle, writeCycle, writeCount, writeData, rd, mis, memAddr);
      checkOutput($sformatf("rand%0d ack cycle", n), 32'(ackCycle), 32'(expAckCycle));
      checkOutput($sformatf("rand%0d rdata", n), rd, modelRdata);
      checkOutput($sformatf("rand%0d misalign", n), 32'(mis), 32'(trap));
      checkOutput($sformatf("rand%0d write count", n), 32'(writeCount), 32'(we && !trap));
      if (we && !trap)
        checkOutput($sformatf("rand%0d mem_wdata", n), writeData, expWord);
    end

    @(negedge clk);
    for (int w = 0; w < 16; w++) begin
      checkOutput($sformatf("final memory word %0d", w), tbMem[128 + w], refWord(32'h200 + 4 * w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
